// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient sequencer: sizes and the
// sequencer state encoding.
package fir_ctrl_pkg;

  localparam int unsigned P_NUM_COEFF  = 40;
  localparam int unsigned P_BANK_DEPTH = 10;
  localparam int unsigned P_DATA_W     = 16;
  localparam int unsigned P_ADDR_W     = 4;
  localparam int unsigned P_NUM_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_TAIL    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5,
    ST_SCAN    = 3'd6
  } state_e;

  // States in which the controller is held in coefficient-update mode.
  function automatic logic is_update_state(input state_e s);
    return (s == ST_ARM) || (s == ST_LOAD) || (s == ST_TAIL);
  endfunction

endpackage

// File: rtl/fir_mod_counter.sv
// Modulo-N up counter with synchronous clear (priority) and count enable.
module fir_mod_counter #(
  parameter int unsigned P_MOD = 10,
  parameter int unsigned P_W   = $clog2(P_MOD)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [P_W-1:0] cnt_o
);

  logic [P_W-1:0] cnt_q;
  logic [P_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == P_W'(P_MOD - 1)) ? '0 : cnt_q + P_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/coeff_load_sequencer.sv
// Drives the 4-bank FIR controller bus: streams 40 coefficients into the
// banks on request, then issues a 10-address read scan per sample strobe.
module coeff_load_sequencer
  import fir_ctrl_pkg::*;
(
  input  logic                       iClk_12M,
  input  logic                       iRst,
  input  logic                       iEnSample_300k,
  input  logic                       iUpdReq,
  input  logic                       iCoeffValid,
  input  logic signed [P_DATA_W-1:0] iCoeffData,
  output logic                       oCoeffReady,
  output logic                       oCoeffiUpdateFlag,
  output logic                       oCsnRam,
  output logic                       oWrnRam,
  output logic [P_ADDR_W-1:0]        oAddrRam,
  output logic signed [P_DATA_W-1:0] oWrDtRam,
  output logic [P_NUM_W-1:0]         oNumOfCoeff,
  output logic                       oBusy,
  output logic                       oLoadDone,
  output logic                       oSampleMiss
);

  state_e state_q, state_d;

  logic                       pend_q, pend_d;
  logic [P_ADDR_W-1:0]        scan_k_q, scan_k_d;
  logic                       flag_q, flag_d;
  logic                       csn_q, csn_d;
  logic                       wrn_q, wrn_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       miss_q, miss_d;
  logic [P_ADDR_W-1:0]        addr_q, addr_d;
  logic signed [P_DATA_W-1:0] data_q, data_d;
  logic [P_NUM_W-1:0]         num_q, num_d;

  logic                       accept_c;
  logic                       cnt_clr_c;
  logic [P_ADDR_W-1:0]        bank_idx;
  logic [P_NUM_W-1:0]         glob_idx;

  // ready_q is only ever high in LOAD, so this is the load handshake.
  assign accept_c  = iCoeffValid & ready_q;
  assign cnt_clr_c = (state_q == ST_ARM);

  fir_mod_counter #(
    .P_MOD (P_BANK_DEPTH),
    .P_W   (P_ADDR_W)
  ) u_bank_cnt (
    .clk   (iClk_12M),
    .rst   (iRst),
    .clr_i (cnt_clr_c),
    .en_i  (accept_c),
    .cnt_o (bank_idx)
  );

  fir_mod_counter #(
    .P_MOD (P_NUM_COEFF),
    .P_W   (P_NUM_W)
  ) u_glob_cnt (
    .clk   (iClk_12M),
    .rst   (iRst),
    .clr_i (cnt_clr_c),
    .en_i  (accept_c),
    .cnt_o (glob_idx)
  );

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath next values, and output decode of the next state.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    scan_k_d = scan_k_q;
    addr_d   = addr_q;
    data_d   = data_q;
    num_d    = num_q;
    miss_d   = 1'b0;
    flag_d   = 1'b0;
    csn_d    = 1'b1;
    wrn_d    = 1'b1;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iUpdReq) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept_c) begin
          data_d = iCoeffData;
          addr_d = bank_idx;
          num_d  = glob_idx;
          if (glob_idx == P_NUM_W'(P_NUM_COEFF - 1)) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A reload request beats a coincident sample strobe.
        if (iUpdReq) begin
          state_d = ST_ARM;
        end else if (iEnSample_300k) begin
          state_d  = ST_SCAN;
          scan_k_d = '0;
          addr_d   = '0;
          num_d    = '0;
        end
      end
      ST_SCAN: begin
        miss_d = iEnSample_300k;
        num_d  = '0;
        if (scan_k_q == P_ADDR_W'(P_BANK_DEPTH)) begin
          if (pend_q || iUpdReq) begin
            state_d = ST_ARM;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          // Cycle k+1 presents address k, giving the 0,0,1..9 sequence.
          scan_k_d = scan_k_q + P_ADDR_W'(1);
          addr_d   = scan_k_q;
          pend_d   = pend_q | iUpdReq;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    flag_d  = is_update_state(state_d);
    wrn_d   = ~flag_d;
    ready_d = (state_d == ST_LOAD);
    busy_d  = flag_d | (state_d == ST_RELEASE);
    done_d  = (state_d == ST_RELEASE);
    if ((state_d == ST_TAIL) || (state_d == ST_SCAN)) begin
      csn_d = 1'b0;
    end else if (state_d == ST_LOAD) begin
      csn_d = ~accept_c;
    end
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      pend_q   <= 1'b0;
      scan_k_q <= '0;
      flag_q   <= 1'b0;
      csn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      num_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      scan_k_q <= scan_k_d;
      flag_q   <= flag_d;
      csn_q    <= csn_d;
      wrn_q    <= wrn_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      miss_q   <= miss_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      num_q    <= num_d;
    end
  end

  assign oCoeffReady       = ready_q;
  assign oCoeffiUpdateFlag = flag_q;
  assign oCsnRam           = csn_q;
  assign oWrnRam           = wrn_q;
  assign oAddrRam          = addr_q;
  assign oWrDtRam          = data_q;
  assign oNumOfCoeff       = num_q;
  assign oBusy             = busy_q;
  assign oLoadDone         = done_q;
  assign oSampleMiss       = miss_q;

endmodule

// File: doc/coeff_load_sequencer.md
# coeff_load_sequencer

Host-side sequencer that sits directly upstream of the 4-bank transposed FIR controller and generates its entire input bus: coefficient-update flag, RAM chip-select/write strobes, bank address, write data and the coefficient index. It accepts 40 signed 16-bit Kaiser-window coefficients over a valid/ready stream and writes them into the four 10-deep coefficient banks. On each 300 kHz sample strobe it issues the 10-address read scan that steps the controller through its accumulate and sum phases.

## Interface
- P_NUM_COEFF, 40, total coefficients (4 banks × P_BANK_DEPTH)
- P_BANK_DEPTH, 10, words per bank
- P_DATA_W, 16, coefficient width
- iClk_12M  in  1  12 MHz clock
- iRst  in  1  reset, asynchronous, active-high
- iEnSample_300k  in  1  one-cycle sample strobe
- iUpdReq  in  1  one-cycle request to reload all coefficients
- iCoeffValid  in  1  coefficient beat valid
- iCoeffData  in  P_DATA_W  signed coefficient
- oCoeffReady  out  1  sequencer accepts a beat
- oCoeffiUpdateFlag  out  1  update mode flag to controller
- oCsnRam  out  1  RAM chip select, active-low
- oWrnRam  out  1  RAM write strobe, active-low
- oAddrRam  out  4  bank address 0..9
- oWrDtRam  out  P_DATA_W  signed write data
- oNumOfCoeff  out  6  global coefficient index 0..39
- oBusy  out  1  load in progress
- oLoadDone  out  1  one-cycle pulse, load complete
- oSampleMiss  out  1  one-cycle pulse, strobe arrived during a scan

## Operation
- All outputs are registered. Reset values: flag=0, csn=1, wrn=1, addr=0, data=0, num=0, ready=0, busy=0, done=0, miss=0. State is ST_IDLE.
- ST_IDLE: flag=0, csn=1, wrn=1. iUpdReq moves the block to ST_ARM. Strobes are ignored.
- ST_ARM, 1 cycle: flag=1, csn=1, wrn=0. This returns the controller from Sum to Idle. Next state is ST_LOAD, with index=0.
- ST_LOAD: flag=1, wrn=0, ready=1.
  - On valid&ready the block registers data=iCoeffData, num=index and addr=index mod 10, with csn=0.
  - In gap cycles, csn=1 and addr/data/num hold their values.
  - Index 39 accepted leads to ST_TAIL.
- ST_TAIL, 1 cycle: ready=0. Beat 39 values and csn=0/wrn=0 are held. This guarantees the controller writes the final beat one cycle after entering its write state.
- ST_RELEASE, 1 cycle: flag=0, csn=1, wrn=1, done=1. Next state is ST_RUN.
- ST_RUN: flag=0, csn=1, wrn=1. iEnSample_300k leads to ST_SCAN. iUpdReq leads to ST_ARM. If both arrive in the same cycle, the update wins and the strobe is dropped.
- ST_SCAN lasts P_BANK_DEPTH+1 = 11 cycles, k = 0..10, with csn=0, wrn=1, flag=0.
  - addr = max(k−1, 0), so scan cycles 1..10 present addresses 0..9.
  - num holds 0.
  - After k=10 the block returns to ST_RUN.
- Any strobe during SCAN pulses oSampleMiss next cycle and is otherwise dropped.
- iUpdReq during SCAN is latched into a pending bit and taken at scan end (ST_ARM). iUpdReq during ARM/LOAD/TAIL/RELEASE is ignored.
- oBusy=1 in ARM, LOAD, TAIL and RELEASE.
- Index is 6-bit and never exceeds 39. The bank address wraps 9→0 at indices 10, 20 and 30.

## Timing
- Handshake output latency: one cycle from valid&ready to the registered csn/addr/data/num.
- Minimum load time is 43 cycles: ARM (1) + 40 beats + TAIL (1) + RELEASE (1).
- Scan latency: the first csn=0 appears one cycle after the strobe. Scan occupancy is 11 cycles, well inside the 40-cycle sample period.
- iRst asserted mid-load or mid-scan forces the reset values asynchronously and discards the partial load. After reset, a fresh iUpdReq is required.

## Structure
- Shared package fir_ctrl_pkg holds:
  - the state encoding (ST_IDLE, ST_ARM, ST_LOAD, ST_TAIL, ST_RELEASE, ST_RUN, ST_SCAN)
  - P_NUM_COEFF, P_BANK_DEPTH, P_DATA_W
- One sub-module, fir_mod_counter, is used twice: a parameterised mod-N counter with enable and clear. It serves both the bank address (N=10) and the global index (N=40).

## Test plan
- Reset, then iUpdReq and 40 back-to-back beats with data 0x0100+i:
  - index 13 shows addr=3, num=13, data=0x010D one cycle after acceptance.
  - TAIL holds 0x0127.
  - done pulses 43 cycles after ARM.
- Load with iCoeffValid low every other cycle: during gaps csn=1 and addr/data/num hold. There are 40 writes in total.
- In RUN, strobe → 11-cycle csn=0 scan with addr sequence 0,0,1,…,9, then csn=1.
- Second strobe 5 cycles into a scan → oSampleMiss pulses and no new scan starts.
- iUpdReq mid-scan → scan completes, then ARM (flag=1, wrn=0, csn=1) and a reload.
- iRst asserted at beat 20 → all outputs return to reset values immediately. The next iUpdReq restarts from index 0.
